// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared RV32 pipeline definitions: opcode classes, forwarding selects and
// hazard-controller state encoding.
package rv_pipe_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } hz_state_t;

  function automatic logic writes_rd(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_JAL);
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller
// (slave): stage opcode/register info in, enables/flushes/forwarding out.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  import rv_pipe_pkg::*;

  logic [6:0]       id_opcode;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [6:0]       ex_opcode;
  logic [4:0]       ex_rd;
  logic [6:0]       mem_opcode;
  logic [4:0]       mem_rd;
  logic [6:0]       wb_opcode;
  logic [4:0]       wb_rd;
  logic             redirect;
  logic             dmem_req;
  logic             dmem_ready;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             exmem_flush;
  logic             memwb_en;
  logic             memwb_bubble;
  fwd_sel_t         fwd_a;
  fwd_sel_t         fwd_b;
  logic             fault;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_opcode, id_rs1, id_rs2, ex_opcode, ex_rd, mem_opcode, mem_rd,
           wb_opcode, wb_rd, redirect, dmem_req, dmem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           exmem_flush, memwb_en, memwb_bubble, fwd_a, fwd_b, fault,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_opcode, id_rs1, id_rs2, ex_opcode, ex_rd, mem_opcode, mem_rd,
           wb_opcode, wb_rd, redirect, dmem_req, dmem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
           exmem_flush, memwb_en, memwb_bubble, fwd_a, fwd_b, fault,
           stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
// Operand forwarding select for one EX source register; the MEM ALU result
// wins over WB write data, loads in MEM have no data yet.
module fwd_select
  import rv_pipe_pkg::*;
(
  input  logic [4:0] rs,
  input  logic [6:0] mem_opcode,
  input  logic [4:0] mem_rd,
  input  logic [6:0] wb_opcode,
  input  logic [4:0] wb_rd,
  output fwd_sel_t   sel
);

  always_comb begin
    sel = FWD_RF;
    if (writes_rd(mem_opcode) && (mem_opcode != OP_LOAD) &&
        (mem_rd != 5'd0) && (mem_rd == rs)) begin
      sel = FWD_MEM;
    end else if (writes_rd(wb_opcode) && (wb_rd != 5'd0) && (wb_rd == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage pipeline sequencing: load-use bubbles, MEM-resolved redirects,
// data-memory freeze with timeout fault, forwarding and perf counters.
module pipe_hazard_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  hz_state_t        state_reg, state_next;
  logic [7:0]       wait_cnt_reg, wait_cnt_next;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;
  logic             fault_reg;
  logic [4:0]       ex_rs_reg [2];
  logic [4:0]       id_rs [2];
  fwd_sel_t         fwd_sel [2];

  logic freeze, load_use, active, stall_evt, flush_evt;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic exmem_en, exmem_flush, memwb_en, memwb_bubble;

  assign id_rs[0] = bus.id_rs1;
  assign id_rs[1] = bus.id_rs2;

  assign freeze   = bus.dmem_req && !bus.dmem_ready;
  assign load_use = (bus.ex_opcode == OP_LOAD) && (bus.ex_rd != 5'd0) &&
                    ((uses_rs1(bus.id_opcode) && (bus.id_rs1 == bus.ex_rd)) ||
                     (uses_rs2(bus.id_opcode) && (bus.id_rs2 == bus.ex_rd)));
  assign active    = (state_reg != FAULT);
  assign stall_evt = active && (freeze || (!bus.redirect && load_use));
  assign flush_evt = active && !freeze && bus.redirect;

  // EX-stage source registers follow ID/EX: held on freeze, zeroed by a bubble.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ex_rs
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ex_rs_reg[gi] <= 5'd0;
        end else if (idex_flush) begin
          ex_rs_reg[gi] <= 5'd0;
        end else if (idex_en) begin
          ex_rs_reg[gi] <= id_rs[gi];
        end
      end

      fwd_select u_fwd (
        .rs         (ex_rs_reg[gi]),
        .mem_opcode (bus.mem_opcode),
        .mem_rd     (bus.mem_rd),
        .wb_opcode  (bus.wb_opcode),
        .wb_rd      (bus.wb_rd),
        .sel        (fwd_sel[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= RUN;
      wait_cnt_reg <= 8'd0;
      fault_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      fault_reg    <= (state_next == FAULT);
    end
  end

  // wait_cnt counts frozen cycles so far; reaching MEM_TIMEOUT trips the fault.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      RUN: begin
        if (freeze) begin
          wait_cnt_next = 8'd1;
          state_next    = (TIMEOUT == 8'd1) ? FAULT : WAIT;
        end
      end
      WAIT: begin
        if (!freeze) begin
          wait_cnt_next = 8'd0;
          state_next    = RUN;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
          if (wait_cnt_next == TIMEOUT) begin
            state_next = FAULT;
          end
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = 8'd0;
      end
    endcase
  end

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_flush   = 1'b0;
    exmem_en     = 1'b1;
    exmem_flush  = 1'b0;
    memwb_en     = 1'b1;
    memwb_bubble = 1'b0;
    if (rst || (state_reg == FAULT) || freeze) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (bus.redirect) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall_evt && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
      if (flush_evt && (flush_cnt_reg != '1)) begin
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign bus.pc_en        = pc_en;
  assign bus.ifid_en      = ifid_en;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_en      = idex_en;
  assign bus.idex_flush   = idex_flush;
  assign bus.exmem_en     = exmem_en;
  assign bus.exmem_flush  = exmem_flush;
  assign bus.memwb_en     = memwb_en;
  assign bus.memwb_bubble = memwb_bubble;
  assign bus.fwd_a        = rst ? FWD_RF : fwd_sel[0];
  assign bus.fwd_b        = rst ? FWD_RF : fwd_sel[1];
  assign bus.fault        = fault_reg;
  assign bus.stall_cnt    = stall_cnt_reg;
  assign bus.flush_cnt    = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (MEM_TIMEOUT=4, 4-bit
// counters so saturation is reachable).
module tb_pipe_hazard_ctrl;
  import rv_pipe_pkg::*;

  localparam int CW = 4;
  localparam logic [6:0] NOP = 7'b0000000;
  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_bubble}
  localparam logic [8:0] C_NORM = 9'b1_1_0_1_0_1_0_1_0;
  localparam logic [8:0] C_LU   = 9'b0_0_0_1_1_1_0_1_0;
  localparam logic [8:0] C_RED  = 9'b1_1_1_1_1_1_1_1_0;
  localparam logic [8:0] C_FRZ  = 9'b0_0_0_0_0_0_0_0_1;

  typedef struct {
    string      tag;
    logic [8:0] ctl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       flt;
  } exp_t;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  pipe_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic stg(input logic [6:0] io, input logic [4:0] r1, input logic [4:0] r2,
                     input logic [6:0] eo, input logic [4:0] ed,
                     input logic [6:0] mo, input logic [4:0] md,
                     input logic [6:0] wo, input logic [4:0] wd);
    bus.id_opcode  = io;  bus.id_rs1 = r1; bus.id_rs2 = r2;
    bus.ex_opcode  = eo;  bus.ex_rd  = ed;
    bus.mem_opcode = mo;  bus.mem_rd = md;
    bus.wb_opcode  = wo;  bus.wb_rd  = wd;
  endtask

  task automatic ctl_in(input logic redir, input logic req, input logic rdy);
    bus.redirect   = redir;
    bus.dmem_req   = req;
    bus.dmem_ready = rdy;
  endtask

  task automatic push(input string tag, input logic [8:0] ctl,
                      input logic [1:0] fa, input logic [1:0] fb, input logic flt);
    exp_t e;
    e.tag = tag; e.ctl = ctl; e.fa = fa; e.fb = fb; e.flt = flt;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    logic [8:0] obs_ctl;
    logic [3:0] obs_fwd;
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL scoreboard_empty observed=0 entries expected=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      obs_ctl = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
                 bus.exmem_en, bus.exmem_flush, bus.memwb_en, bus.memwb_bubble};
      obs_fwd = {bus.fwd_a, bus.fwd_b};
      checks++;
      assert (obs_ctl === e.ctl) else begin
        failures++;
        $error("FAIL %s_ctl observed=%b expected=%b", e.tag, obs_ctl, e.ctl);
      end
      checks++;
      assert (obs_fwd === {e.fa, e.fb}) else begin
        failures++;
        $error("FAIL %s_fwd observed=%b expected=%b", e.tag, obs_fwd, {e.fa, e.fb});
      end
      checks++;
      assert (bus.fault === e.flt) else begin
        failures++;
        $error("FAIL %s_fault observed=%b expected=%b", e.tag, bus.fault, e.flt);
      end
      $display("step %-10s ctl=%b fwd=%b fault=%b stall=%0d flush=%0d",
               e.tag, obs_ctl, obs_fwd, bus.fault, bus.stall_cnt, bus.flush_cnt);
    end
  endtask

  // One pipeline cycle: expectation queued with the stimulus, checked mid-cycle.
  task automatic apply(input string tag, input logic [8:0] ctl,
                       input logic [1:0] fa, input logic [1:0] fb, input logic flt);
    push(tag, ctl, fa, fb, flt);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    stg(OP_R, 5, 7, OP_LOAD, 5, NOP, 0, NOP, 0);
    ctl_in(1'b1, 1'b0, 1'b0);
    apply("reset", C_FRZ, 2'b00, 2'b00, 1'b0);
    chk_cnt("reset_stall", bus.stall_cnt, 0);
    chk_cnt("reset_flush", bus.flush_cnt, 0);
    rst = 1'b0;
    ctl_in(1'b0, 1'b0, 1'b0);

    // Load-use: load x5 in EX, add x6,x5,x7 in ID.
    stg(OP_R, 5, 7, OP_LOAD, 5, NOP, 0, NOP, 0);
    apply("lu_stall", C_LU, 2'b00, 2'b00, 1'b0);
    stg(OP_R, 5, 7, NOP, 0, OP_LOAD, 5, NOP, 0);
    apply("lu_bubble", C_NORM, 2'b00, 2'b00, 1'b0);
    stg(NOP, 0, 0, OP_R, 6, NOP, 0, OP_LOAD, 5);
    apply("lu_fwd_wb", C_NORM, 2'b10, 2'b00, 1'b0);
    chk_cnt("lu_stall_cnt", bus.stall_cnt, 1);

    // MEM beats WB; a load in MEM cannot forward.
    stg(OP_R, 3, 3, NOP, 0, NOP, 0, NOP, 0);
    apply("mw_load", C_NORM, 2'b00, 2'b00, 1'b0);
    stg(OP_R, 3, 3, OP_R, 4, OP_I, 3, OP_I, 3);
    apply("mem_wins", C_NORM, 2'b01, 2'b01, 1'b0);
    stg(NOP, 0, 0, NOP, 0, OP_LOAD, 3, OP_R, 3);
    apply("memld_wb", C_NORM, 2'b10, 2'b10, 1'b0);

    // x0 never hazards; rs2 of I-type is unused; store rs2 is used.
    stg(OP_R, 0, 0, OP_LOAD, 0, OP_I, 0, OP_I, 0);
    apply("x0", C_NORM, 2'b00, 2'b00, 1'b0);
    stg(OP_I, 1, 9, OP_LOAD, 9, NOP, 0, NOP, 0);
    apply("i_rs2", C_NORM, 2'b00, 2'b00, 1'b0);
    stg(OP_STORE, 1, 9, OP_LOAD, 9, NOP, 0, NOP, 0);
    apply("st_rs2", C_LU, 2'b00, 2'b00, 1'b0);
    stg(OP_STORE, 1, 9, NOP, 0, OP_LOAD, 9, NOP, 0);
    apply("st_after", C_NORM, 2'b00, 2'b00, 1'b0);
    chk_cnt("st_stall_cnt", bus.stall_cnt, 2);

    // Redirect overrides a simultaneous load-use.
    stg(OP_R, 5, 7, OP_LOAD, 5, NOP, 0, NOP, 0);
    ctl_in(1'b1, 1'b0, 1'b0);
    apply("redirect", C_RED, 2'b00, 2'b00, 1'b0);
    stg(NOP, 0, 0, NOP, 0, NOP, 0, NOP, 0);
    ctl_in(1'b0, 1'b0, 1'b0);
    apply("post_redir", C_NORM, 2'b00, 2'b00, 1'b0);
    chk_cnt("redir_flush_cnt", bus.flush_cnt, 1);
    chk_cnt("redir_stall_cnt", bus.stall_cnt, 2);

    rst = 1'b1;
    #1;
    chk_cnt("pulse_stall", bus.stall_cnt, 0);
    chk_cnt("pulse_flush", bus.flush_cnt, 0);
    rst = 1'b0;

    // Freeze for 3 cycles with redirect and load-use ignored, then advance.
    stg(OP_R, 5, 7, OP_LOAD, 5, OP_LOAD, 3, NOP, 0);
    ctl_in(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) apply("freeze", C_FRZ, 2'b00, 2'b00, 1'b0);
    stg(NOP, 0, 0, NOP, 0, OP_LOAD, 3, NOP, 0);
    ctl_in(1'b0, 1'b1, 1'b1);
    apply("mem_done", C_NORM, 2'b00, 2'b00, 1'b0);
    chk_cnt("frz_stall_cnt", bus.stall_cnt, 3);
    chk_cnt("frz_flush_cnt", bus.flush_cnt, 0);
    ctl_in(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) apply("freeze2", C_FRZ, 2'b00, 2'b00, 1'b0);
    ctl_in(1'b0, 1'b1, 1'b1);
    apply("mem_done2", C_NORM, 2'b00, 2'b00, 1'b0);

    // Timeout: 4 frozen cycles, then sticky fault.
    ctl_in(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) apply("pre_fault", C_FRZ, 2'b00, 2'b00, 1'b0);
    ctl_in(1'b1, 1'b1, 1'b0);
    apply("fault", C_FRZ, 2'b00, 2'b00, 1'b1);
    ctl_in(1'b0, 1'b1, 1'b1);
    apply("fault_stky", C_FRZ, 2'b00, 2'b00, 1'b1);
    chk_cnt("flt_stall_cnt", bus.stall_cnt, 10);
    chk_cnt("flt_flush_cnt", bus.flush_cnt, 0);

    // Asynchronous reset in the middle of FAULT acts without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    push("async_rst", C_FRZ, 2'b00, 2'b00, 1'b0);
    check_out();
    chk_cnt("arst_stall", bus.stall_cnt, 0);
    chk_cnt("arst_flush", bus.flush_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    stg(NOP, 0, 0, NOP, 0, NOP, 0, NOP, 0);
    ctl_in(1'b0, 1'b0, 1'b0);
    apply("after_rst", C_NORM, 2'b00, 2'b00, 1'b0);

    // Saturation of both 4-bit counters.
    stg(OP_R, 5, 7, OP_LOAD, 5, NOP, 0, NOP, 0);
    for (int i = 0; i < 17; i++) apply("sat_lu", C_LU, 2'b00, 2'b00, 1'b0);
    chk_cnt("sat_stall", bus.stall_cnt, 15);
    stg(NOP, 0, 0, NOP, 0, NOP, 0, NOP, 0);
    ctl_in(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) apply("sat_red", C_RED, 2'b00, 2'b00, 1'b0);
    chk_cnt("sat_flush", bus.flush_cnt, 15);
    chk_cnt("sat_stall_hold", bus.stall_cnt, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central sequencing controller for the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB). It generates per-stage register enables and flushes, and the EX operand forwarding selects. It handles three hazard classes: load-use stalls, branch/JAL redirects resolved in MEM, and multi-cycle data-memory waits, with a timeout fault. It replaces ad-hoc stall/flush logic scattered in the CPU top level, and it exposes saturating stall/flush performance counters.

Parameters:
MEM_TIMEOUT, 16, max consecutive frozen cycles waiting on dmem_ready before fault (range 1..255)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-high reset
id_opcode  in  7  opcode of instruction in ID
id_rs1  in  5  rs1 of ID instruction
id_rs2  in  5  rs2 of ID instruction
ex_opcode  in  7  opcode in EX
ex_rd  in  5  rd in EX
mem_opcode  in  7  opcode in MEM
mem_rd  in  5  rd in MEM
wb_opcode  in  7  opcode in WB
wb_rd  in  5  rd in WB
redirect  in  1  branch taken or JAL in MEM; PC target valid
dmem_req  in  1  MEM stage holds a load/store needing memory
dmem_ready  in  1  data memory completes the access this cycle
pc_en  out  1  PC update enable
ifid_en / ifid_flush  out  1 each  IF/ID enable / clear-to-nop
idex_en / idex_flush  out  1 each  ID/EX enable / bubble insert
exmem_en / exmem_flush  out  1 each  EX/MEM enable / clear
memwb_en / memwb_bubble  out  1 each  MEM/WB enable / write nop
fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 01 MEM ALU result, 10 WB write data
fault  out  1  sticky memory-timeout fault
stall_cnt  out  CNT_W  cycles with any stall/freeze, saturating
flush_cnt  out  CNT_W  redirect events, saturating

Behaviour:
- Opcode classes: writes-rd = R 0110011, I 0010011, load 0000011, JAL 1101111. Uses rs1 = R, I, load, store 0100011, branch 1100011. Uses rs2 = R, store, branch.
- rd==0 never matches for forwarding or stall purposes.
- Forwarding (combinational, every cycle):
  - fwd_a=01 if mem writes-rd, is not load, and mem_rd==ID/EX rs1.
  - Else fwd_a=10 if wb writes-rd and wb_rd matches rs1.
  - Else fwd_a=00.
  - fwd_b is the same using rs2.
  - The forwarding unit is fed the EX-stage rs1/rs2 (registered from id_rs*). EX rs1/rs2 are held internally in a 2-entry shadow that advances when idex_en=1 and clears on idex_flush.
  - MEM over WB priority.
- Load-use: ex_opcode==load, ex_rd!=0, and ex_rd matches an ID source that is actually used. Response that cycle: pc_en=0, ifid_en=0, idex_flush=1, all else enabled. Exactly one bubble.
- Redirect (MEM resolves): pc_en=1; ifid_flush, idex_flush and exmem_flush all =1; memwb_en=1. flush_cnt+1.
- Freeze: asserted when dmem_req && !dmem_ready. Response: all *_en=0, all flushes=0, memwb_bubble=1, stall_cnt+1.
- Priority: fault > freeze > redirect > load-use > normal. Redirect and load-use are ignored while frozen. redirect stays asserted until the MEM instruction advances.
- Normal: all enables 1, flushes 0, memwb_bubble 0.
- FSM:
  - RUN: dmem_req && !dmem_ready -> WAIT, wait_cnt=1.
  - WAIT: dmem_ready -> RUN (that cycle advances normally). Otherwise wait_cnt+1; when wait_cnt==MEM_TIMEOUT -> FAULT.
  - FAULT: terminal until rst. All enables 0, memwb_bubble=1, fault=1, counters frozen.
- Counters saturate at all-ones, never wrap.
- Reset (async, immediate): state=RUN, wait_cnt=0, shadow rs=0, counters=0, fault=0. While rst=1 all enables=0, flushes=0, fwd=00, memwb_bubble=1.
- Release of rst takes effect at the first following rising edge.

Decomposition:
- Package rv_pipe_pkg holds:
  - opcode constants: OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL
  - fwd_sel_t encodings: FWD_RF, FWD_MEM, FWD_WB
  - hz_state_t enumeration: RUN, WAIT, FAULT
  - class helper functions: writes_rd, uses_rs1, uses_rs2
- Sub-module fwd_select: combinational, one instance per operand. Inputs: rs, mem/wb opcode+rd. Output: 2-bit select.

Test Plan:
- Load x5 in EX with ID `add x6,x5,x7` -> one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle normal, fwd_a=10; stall_cnt=1.
- `addi x3,x0,4` in MEM plus `add x4,x3,x3` in EX, with x3 also in WB -> fwd_a=fwd_b=01 (MEM wins).
- Load x0 in EX, ID uses x0 -> no stall; fwd=00.
- redirect=1 with load-use condition present -> ifid/idex/exmem_flush=1, pc_en=1, no stall; flush_cnt=1.
- dmem_req=1, dmem_ready low 3 cycles then high -> 3 frozen cycles (memwb_bubble=1), advance on 4th, state RUN; stall_cnt=3.
- MEM_TIMEOUT=4, dmem_ready stuck low -> FAULT after 4 frozen cycles, fault=1 sticky; async rst mid-FAULT -> fault=0 immediately, counters=0.
